// File: rtl/pc_stack_unit.sv
// Program counter with a hardware return-address stack.
// On each enabled cycle one next PC is chosen: sequential, absolute load,
// PC-relative branch, call (pushes the return address) or return (pops it).
// Stack misuse, meaning a CALL while full or a RET while empty, raises a sticky fault.
// The op decode is purely combinational. There is no FSM: the only state is
// the PC, the depth counter, the fault flag and the stack storage.
module pc_stack_unit #(
  parameter int unsigned             WIDTH        = 16,
  parameter int unsigned             STACK_DEPTH  = 8,
  parameter logic [WIDTH-1:0]        RESET_VECTOR = '0,
  parameter int unsigned             INC          = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               pc_enable,
  input  logic [2:0]                         op,
  input  logic [WIDTH-1:0]                   bus,
  input  logic                               clr_fault,
  output logic [WIDTH-1:0]                   out,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               fault
);

  localparam int unsigned DW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned AW = $clog2(STACK_DEPTH);
  localparam logic [WIDTH-1:0] INC_W  = WIDTH'(INC);
  localparam logic [DW-1:0]    FULL_D = DW'(STACK_DEPTH);

  localparam logic [2:0] OP_INC  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_REL  = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;

  // Stack storage. Its contents are don't-care after reset, so it has no reset.
  logic [WIDTH-1:0] stack_mem [STACK_DEPTH];

  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] top;
  logic [DW-1:0]    depth_m1;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    top_idx;

  logic [WIDTH-1:0] next_out;
  logic [DW-1:0]    next_depth;
  logic             push;
  logic             err;

  assign seq_pc   = out + INC_W;
  assign depth_m1 = depth - DW'(1);
  // A push only happens while depth < STACK_DEPTH, so depth fits the index width.
  assign push_idx = depth[AW-1:0];
  assign top_idx  = depth_m1[AW-1:0];
  assign top      = stack_mem[top_idx];

  // The flags are decoded straight from the depth register.
  assign stack_full  = (depth == FULL_D);
  assign stack_empty = (depth == '0);

  // Next-PC, depth and fault-event decode for the current op.
  always_comb begin
    next_out   = out;
    next_depth = depth;
    push       = 1'b0;
    err        = 1'b0;
    if (pc_enable) begin
      case (op)
        OP_INC:  next_out = seq_pc;
        OP_LOAD: next_out = bus;
        OP_REL:  next_out = out + bus;
        OP_CALL: begin
          if (stack_full) begin
            err = 1'b1;
          end else begin
            push       = 1'b1;
            next_out   = bus;
            next_depth = depth + DW'(1);
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            err = 1'b1;
          end else begin
            next_out   = top;
            next_depth = depth_m1;
          end
        end
        default: begin
          // HOLD and the reserved encodings change nothing.
        end
      endcase
    end
  end

  // PC and depth registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out   <= RESET_VECTOR;
      depth <= '0;
    end else begin
      out   <= next_out;
      depth <= next_depth;
    end
  end

  // Sticky fault. A new error in the same cycle as a clear wins over the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault <= 1'b0;
    end else if (err) begin
      fault <= 1'b1;
    end else if (clr_fault) begin
      fault <= 1'b0;
    end
  end

  // Return-address write. A RET right after a CALL reads the entry written here.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_mem[push_idx] <= seq_pc;
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit with RESET_VECTOR = 16'h0100 and an 8-entry stack.
// A table of single-cycle vectors is followed by hand-written multi-cycle sequences.
module tb_pc_stack_unit;

  localparam int W  = 16;
  localparam int SD = 8;
  localparam int DW = $clog2(SD + 1);

  localparam logic [2:0] OP_INC  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_REL  = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;
  localparam logic [2:0] OP_HOLD = 3'b101;

  logic          clk;
  logic          rst;
  logic          pc_enable;
  logic [2:0]    op;
  logic [W-1:0]  bus;
  logic          clr_fault;
  logic [W-1:0]  out;
  logic [DW-1:0] depth;
  logic          stack_full;
  logic          stack_empty;
  logic          fault;

  int n_checks;
  int n_fails;

  logic [W-1:0] exp_q[$];

  typedef struct packed {
    logic          en;
    logic [2:0]    op;
    logic [W-1:0]  bus;
    logic          clr;
    logic [W-1:0]  e_out;
    logic [DW-1:0] e_depth;
    logic          e_fault;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  pc_stack_unit #(
    .WIDTH(W),
    .STACK_DEPTH(SD),
    .RESET_VECTOR(16'h0100),
    .INC(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pc_enable(pc_enable),
    .op(op),
    .bus(bus),
    .clr_fault(clr_fault),
    .out(out),
    .depth(depth),
    .stack_full(stack_full),
    .stack_empty(stack_empty),
    .fault(fault)
  );

  // Clock generation: 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_all(input string name, input logic [W-1:0] e_out,
                           input logic [DW-1:0] e_depth, input logic e_fault);
    logic e_full;
    logic e_empty;
    e_full  = (e_depth == DW'(SD));
    e_empty = (e_depth == '0);
    n_checks++;
    if (out !== e_out) begin
      n_fails++;
      $display("FAIL %s out: got %h expected %h", name, out, e_out);
    end
    n_checks++;
    if (depth !== e_depth) begin
      n_fails++;
      $display("FAIL %s depth: got %0d expected %0d", name, depth, e_depth);
    end
    n_checks++;
    if (stack_full !== e_full) begin
      n_fails++;
      $display("FAIL %s stack_full: got %b expected %b", name, stack_full, e_full);
    end
    n_checks++;
    if (stack_empty !== e_empty) begin
      n_fails++;
      $display("FAIL %s stack_empty: got %b expected %b", name, stack_empty, e_empty);
    end
    n_checks++;
    if (fault !== e_fault) begin
      n_fails++;
      $display("FAIL %s fault: got %b expected %b", name, fault, e_fault);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 unit after the rising edge.
  task automatic step(input logic en, input logic [2:0] o, input logic [W-1:0] b,
                      input logic clr);
    pc_enable = en;
    op        = o;
    bus       = b;
    clr_fault = clr;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic en, input logic [2:0] o, input logic [W-1:0] b,
                              input logic clr, input logic [W-1:0] e_out,
                              input logic [DW-1:0] e_depth, input logic e_fault);
    vec_t v;
    v.en = en; v.op = o; v.bus = b; v.clr = clr;
    v.e_out = e_out; v.e_depth = e_depth; v.e_fault = e_fault;
    return v;
  endfunction

  initial begin
    logic [W-1:0] cur;
    logic [W-1:0] ret_pc;
    n_checks = 0;
    n_fails  = 0;

    vecs[0]  = mk(1, OP_INC,  16'h0000, 0, 16'h0101, 0, 0);
    vecs[1]  = mk(1, OP_INC,  16'h0000, 0, 16'h0102, 0, 0);
    vecs[2]  = mk(1, OP_INC,  16'h0000, 0, 16'h0103, 0, 0);
    vecs[3]  = mk(1, OP_LOAD, 16'h0010, 0, 16'h0010, 0, 0);
    vecs[4]  = mk(1, OP_CALL, 16'h0200, 0, 16'h0200, 1, 0);
    vecs[5]  = mk(1, OP_INC,  16'h0000, 0, 16'h0201, 1, 0);
    vecs[6]  = mk(1, OP_RET,  16'h0000, 0, 16'h0011, 0, 0);
    vecs[7]  = mk(1, OP_CALL, 16'h0300, 0, 16'h0300, 1, 0);
    vecs[8]  = mk(1, OP_RET,  16'h0000, 0, 16'h0012, 0, 0);
    vecs[9]  = mk(1, OP_LOAD, 16'hFFFE, 0, 16'hFFFE, 0, 0);
    vecs[10] = mk(1, OP_INC,  16'h0000, 0, 16'hFFFF, 0, 0);
    vecs[11] = mk(1, OP_INC,  16'h0000, 0, 16'h0000, 0, 0);
    vecs[12] = mk(1, OP_LOAD, 16'h0005, 0, 16'h0005, 0, 0);
    vecs[13] = mk(1, OP_REL,  16'hFFFB, 0, 16'h0000, 0, 0);
    vecs[14] = mk(1, OP_HOLD, 16'h1111, 0, 16'h0000, 0, 0);
    vecs[15] = mk(1, 3'b110,  16'h2222, 0, 16'h0000, 0, 0);
    vecs[16] = mk(1, 3'b111,  16'h3333, 0, 16'h0000, 0, 0);
    vecs[17] = mk(0, OP_CALL, 16'h1234, 0, 16'h0000, 0, 0);
    vecs[18] = mk(1, OP_REL,  16'h0010, 0, 16'h0010, 0, 0);
    vecs[19] = mk(1, OP_REL,  16'h8000, 0, 16'h8010, 0, 0);
    vecs[20] = mk(1, OP_LOAD, 16'h0010, 0, 16'h0010, 0, 0);

    // Reset sequence, then a check of the reset state.
    rst = 1'b0; pc_enable = 1'b0; op = OP_INC; bus = '0; clr_fault = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    check_all("reset", 16'h0100, 0, 0);

    // Apply the single-cycle vectors from the table.
    for (int i = 0; i < NV; i++) begin
      step(vecs[i].en, vecs[i].op, vecs[i].bus, vecs[i].clr);
      check_all($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_depth, vecs[i].e_fault);
    end

    // Nine CALLs: the 8th fills the stack and the 9th faults without any change.
    cur = 16'h0010;
    for (int i = 0; i < 9; i++) begin
      step(1, OP_CALL, 16'h1000 + W'(i), 0);
      if (i < SD) begin
        exp_q.push_back(cur + 16'h0001);
        cur = 16'h1000 + W'(i);
        check_all($sformatf("call%0d", i), cur, DW'(exp_q.size()), 0);
      end else begin
        check_all("call_full", cur, DW'(SD), 1);
      end
    end
    step(1, OP_HOLD, 16'h0000, 1);
    check_all("clr_after_full", cur, DW'(SD), 0);

    // Unwind the stack and compare each return address with the model.
    while (exp_q.size() > 0) begin
      ret_pc = exp_q.pop_back();
      step(1, OP_RET, 16'h0000, 0);
      check_all("unwind", ret_pc, DW'(exp_q.size()), 0);
      cur = ret_pc;
    end

    // RET on an empty stack, then a clear that collides with a new error.
    step(1, OP_RET, 16'h0000, 0);
    check_all("ret_empty", cur, 0, 1);
    step(1, OP_RET, 16'h0000, 1);
    check_all("clr_vs_err", cur, 0, 1);
    // The clear still acts while the PC is disabled.
    step(0, OP_HOLD, 16'h0000, 1);
    check_all("clr_disabled", cur, 0, 0);

    // Asynchronous reset in the middle of a cycle, with a non-empty stack.
    step(1, OP_CALL, 16'h0400, 0);
    check_all("pre_reset_call", 16'h0400, 1, 0);
    step(1, OP_INC, 16'h0000, 0);
    #3 rst = 1'b0;
    #1;
    check_all("async_reset", 16'h0100, 0, 0);
    #2 rst = 1'b1;
    step(1, OP_INC, 16'h0000, 0);
    check_all("after_reset", 16'h0101, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
